quadrant_select_fsm: RTL and testbench

// Player-side quadrant selector for the VGA memory game. Synchronises and edge-detects raw push

---
 rtl/quadrant_select_fsm_if.sv | 29 ++
 rtl/quadrant_select_fsm.sv | 155 +++++++++++++++
 tb/tb_quadrant_select_fsm.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/quadrant_select_fsm_if.sv
// Player-side quadrant selector bus: round control from the main FSM, raw buttons,
// and the selection result. The master drives requests/buttons, the slave is the selector.
interface quadrant_select_fsm_if;
  logic       start;
  logic       abort;
  logic [1:0] target_quadrant;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_ok;
  logic [1:0] cursor_quadrant;
  logic       sel_valid;
  logic       sel_match;
  logic       timeout;
  logic       busy;

  modport master (
    output start, abort, target_quadrant,
    output btn_up, btn_down, btn_left, btn_right, btn_ok,
    input  cursor_quadrant, sel_valid, sel_match, timeout, busy
  );

  modport slave (
    input  start, abort, target_quadrant,
    input  btn_up, btn_down, btn_left, btn_right, btn_ok,
    output cursor_quadrant, sel_valid, sel_match, timeout, busy
  );
endinterface

// File: rtl/quadrant_select_fsm.sv
// Quadrant selector for the VGA memory game: button sync/edge detect, 2x2 cursor, confirm/timeout.
// Optional per-button debounce filter enabled by defining DEBOUNCE_EN.
module quadrant_select_fsm #(
  parameter int DEB_CYCLES     = 500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input logic                  clk,
  input logic                  rst_n,
  quadrant_select_fsm_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SELECT, REPORT, RELEASE} state_t;

  // Button vector order: [0] ok, [1] up, [2] down, [3] left, [4] right
  logic [4:0] w_raw;
  logic [4:0] w_lvl;
  logic [4:0] w_press;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] r_lvl_q;

  state_t       r_state;
  logic [1:0]   r_cursor;
  logic [TW-1:0] r_cnt;
  logic         r_sel_valid;
  logic         r_sel_match;
  logic         r_timeout;
  logic         r_busy;

  assign w_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_ok};

  if (DEB_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_range
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] r_deb_cnt [5];
  logic [4:0]    r_flt;

  // Filtered level flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flt <= '0;
      for (int i = 0; i < 5; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] != r_flt[i]) begin
          if (r_deb_cnt[i] == DLAST) begin
            r_flt[i]     <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_lvl = r_flt;
`else
  assign w_lvl = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lvl_q <= '0;
    else        r_lvl_q <= w_lvl;
  end

  assign w_press = w_lvl & ~r_lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cursor    <= 2'b00;
      r_cnt       <= '0;
      r_sel_valid <= 1'b0;
      r_sel_match <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sel_valid <= 1'b0;
      r_sel_match <= 1'b0;
      r_timeout   <= 1'b0;
      if (bus.abort) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_state  <= SELECT;
              r_cursor <= 2'b00;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
            end
          end
          SELECT: begin
            // Confirm beats an expiring counter; the counter stops at TLAST so it never wraps
            if (w_press[0]) begin
              r_state <= REPORT;
            end else if (r_cnt == TLAST) begin
              r_timeout <= 1'b1;
              r_state   <= IDLE;
              r_busy    <= 1'b0;
            end else begin
              if (w_press[1] || w_press[2])      r_cursor[1] <= ~r_cursor[1];
              else if (w_press[3] || w_press[4]) r_cursor[0] <= ~r_cursor[0];
              r_cnt <= r_cnt + 1'b1;
            end
          end
          REPORT: begin
            r_sel_valid <= 1'b1;
            r_sel_match <= (r_cursor == bus.target_quadrant);
            r_state     <= RELEASE;
          end
          RELEASE: begin
            if (!w_lvl[0]) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cursor_quadrant = r_cursor;
  assign bus.sel_valid       = r_sel_valid;
  assign bus.sel_match       = r_sel_match;
  assign bus.timeout         = r_timeout;
  assign bus.busy            = r_busy;

endmodule

// File: tb/tb_quadrant_select_fsm.sv
// Bench for quadrant_select_fsm: directed scenarios plus random buttons/start/abort,
// compared each cycle against a cycle-level behavioural model of the selector.
module tb_quadrant_select_fsm;
  localparam int DEB = 4;
  localparam int TO  = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  quadrant_select_fsm_if bus ();

  quadrant_select_fsm #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 choosing, 2 confirming, 3 waiting for ok release
  int         m_mode, m_row, m_col, m_cnt;
  bit         e_valid, e_match, e_to;
  logic [4:0] rh[$];
  logic [4:0] m_flt, m_flt_prev;

  int n_valid, n_to;
  bit last_match, seen01, seen_move;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_row = 0; m_col = 0; m_cnt = 0;
    e_valid = 0; e_match = 0; e_to = 0;
    rh = {};
    repeat (DEB + 4) rh.push_back(5'b0);
    m_flt = '0; m_flt_prev = '0;
  endtask

  task automatic model_edge(input logic [4:0] raw, input logic st, input logic ab,
                            input logic [1:0] tq);
    logic [4:0] lvl, press;
    rh.push_back(raw);
`ifdef DEBOUNCE_EN
    begin
      logic [4:0] nf;
      lvl   = m_flt;
      press = m_flt & ~m_flt_prev;
      for (int b = 0; b < 5; b++) begin
        bit all_diff = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (rh[rh.size()-3-j][b] == m_flt[b]) all_diff = 1'b0;
        nf[b] = all_diff ? ~m_flt[b] : m_flt[b];
      end
      m_flt_prev = m_flt;
      m_flt      = nf;
    end
`else
    lvl   = rh[rh.size()-3];
    press = lvl & ~rh[rh.size()-4];
`endif
    if (rh.size() > 32) void'(rh.pop_front());
    e_valid = 0; e_to = 0; e_match = 0;
    if (ab) begin
      m_mode = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: if (st) begin m_mode = 1; m_row = 0; m_col = 0; m_cnt = 0; end
        1: begin
          if (press[0]) m_mode = 2;
          else if (m_cnt == TO - 1) begin e_to = 1; m_mode = 0; end
          else begin
            if (press[1] || press[2])      m_row ^= 1;
            else if (press[3] || press[4]) m_col ^= 1;
            m_cnt++;
          end
        end
        2: begin e_valid = 1; e_match = ((m_row * 2 + m_col) == tq); m_mode = 3; end
        default: if (!lvl[0]) m_mode = 0;
      endcase
    end
  endtask

  task automatic step();
    logic [4:0] raw;
    @(posedge clk);
    raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_ok};
    model_edge(raw, bus.start, bus.abort, bus.target_quadrant);
    #1;
    check("cursor",    bus.cursor_quadrant, 8'(m_row * 2 + m_col));
    check("sel_valid", bus.sel_valid, e_valid);
    check("sel_match", bus.sel_match, e_match);
    check("timeout",   bus.timeout,   e_to);
    check("busy",      bus.busy,      (m_mode != 0));
    if (bus.sel_valid) begin n_valid++; last_match = bus.sel_match; end
    if (bus.timeout) n_to++;
    if (bus.cursor_quadrant == 2'b01) seen01 = 1'b1;
    if (bus.cursor_quadrant != 2'b00) seen_move = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_tracking();
    n_valid = 0; n_to = 0; last_match = 0; seen01 = 0; seen_move = 0;
  endtask

  task automatic buttons_off();
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0; bus.btn_ok = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cursor"}, bus.cursor_quadrant, 8'h0);
    check({tag, "_valid"},  bus.sel_valid, 8'h0);
    check({tag, "_match"},  bus.sel_match, 8'h0);
    check({tag, "_timeout"}, bus.timeout, 8'h0);
    check({tag, "_busy"},   bus.busy, 8'h0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    buttons_off();
    bus.start = 0; bus.abort = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    buttons_off();
    bus.start = 0; bus.abort = 0; bus.target_quadrant = 2'b00;
    model_reset();
    #2;
    apply_reset("reset");

    // Correct guess: right then down reaches 11, target 11
    clear_tracking();
    bus.target_quadrant = 2'b11;
    pulse_start();
    bus.btn_right = 1; step();
    bus.btn_down  = 1; step();
    bus.btn_ok    = 1; run(14);
    buttons_off();     run(8);
    check("hit_seen01", seen01, 1);
    check("hit_cursor", bus.cursor_quadrant, 8'h3);
    check("hit_valid_count", n_valid, 1);
    check("hit_match", last_match, 1);
    check("hit_idle", bus.busy, 0);

    // Wrong guess with ok held: stays busy until ok released
    clear_tracking();
    bus.target_quadrant = 2'b10;
    pulse_start();
    bus.btn_right = 1; step();
    bus.btn_down  = 1; step();
    bus.btn_ok    = 1; run(16);
    check("miss_held_busy", bus.busy, 1);
    check("miss_valid_count", n_valid, 1);
    check("miss_match", last_match, 0);
    buttons_off(); run(8);
    check("miss_released_idle", bus.busy, 0);

    // No buttons: single timeout pulse
    clear_tracking();
    pulse_start();
    run(TO + 6);
    check("to_count", n_to, 1);
    check("to_no_valid", n_valid, 0);
    check("to_idle", bus.busy, 0);

    // up and ok in the same cycle: confirm wins, cursor stays 00
    clear_tracking();
    bus.target_quadrant = 2'b00;
    pulse_start();
    bus.btn_up = 1; bus.btn_ok = 1; run(12);
    buttons_off(); run(8);
    check("okwins_valid", n_valid, 1);
    check("okwins_match", last_match, 1);
    check("okwins_no_move", seen_move, 0);

    // Async reset in the middle of a round with cursor at 11
    clear_tracking();
    pulse_start();
    bus.btn_left = 1; step();
    bus.btn_up   = 1; run(10);
    check("mid_cursor", bus.cursor_quadrant, 8'h3);
    check("mid_busy", bus.busy, 1);
    apply_reset("async_reset");

`ifdef DEBOUNCE_EN
    // Short glitch rejected, long press accepted once
    clear_tracking();
    pulse_start();
    bus.btn_right = 1; run(2);
    bus.btn_right = 0; run(5);
    check("deb_glitch", bus.cursor_quadrant, 8'h0);
    bus.btn_right = 1; run(6);
    bus.btn_right = 0; run(2);
    check("deb_press", bus.cursor_quadrant, 8'h1);
    bus.abort = 1; step(); bus.abort = 0; run(12);
`endif

    // Random traffic in two activity regimes
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 800; c++) begin
        int tog = (phase == 0) ? 5 : 30;
        if ($urandom_range(0, tog) == 0) bus.btn_ok    = ~bus.btn_ok;
        if ($urandom_range(0, tog) == 0) bus.btn_up    = ~bus.btn_up;
        if ($urandom_range(0, tog) == 0) bus.btn_down  = ~bus.btn_down;
        if ($urandom_range(0, tog) == 0) bus.btn_left  = ~bus.btn_left;
        if ($urandom_range(0, tog) == 0) bus.btn_right = ~bus.btn_right;
        bus.start           = ($urandom_range(0, 7) == 0);
        bus.abort           = ($urandom_range(0, 59) == 0);
        bus.target_quadrant = 2'($urandom_range(0, 3));
        step();
      end
    end
    bus.start = 0; bus.abort = 0;
    buttons_off();
    run(TO + 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
